pipe_fetch_unit: RTL

//  IF stage and IF/ID pipeline register for the 5-stage MIPS pipeline. Produces the dpc4/inst

---
 rtl/pipe_fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fetch_unit
// Brief    : IF stage plus IF/ID register with req/ready instruction fetch,
//            decode-driven redirect and one-instruction branch delay slot.
// Revision : 1.0
// ============================================================================
module pipe_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    input  logic [1:0]  pcsource,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ptgt;
    logic        r_pending;
    logic        r_req;
    logic [31:0] r_dpc4;
    logic [31:0] r_inst;
    logic        r_dvalid;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc4;

    logic        w_xfer;
    logic        w_redir;
    logic [31:0] w_tgt_raw;
    logic [31:0] w_tgt;
    logic [31:0] w_pc4;
    logic [31:0] w_seq;
    logic [31:0] w_next;

    assign w_xfer = r_req & imem_ready;
    // A redirect belongs to the instruction leaving IF/ID; bubbles and a
    // branch whose delay slot is still outstanding never redirect.
    assign w_redir = r_dvalid & wpcir & (pcsource != 2'b00) & ~r_pending;

    always_comb begin
        w_tgt_raw = bpc;
        case (pcsource)
            2'b01:   w_tgt_raw = bpc;
            2'b10:   w_tgt_raw = rpc;
            2'b11:   w_tgt_raw = jpc;
            default: w_tgt_raw = bpc;
        endcase
    end

    assign w_tgt  = {w_tgt_raw[31:2], 2'b00};
    assign w_pc4  = r_pc + 32'd4;
    assign w_seq  = r_pending ? r_ptgt : w_pc4;
    assign w_next = w_redir ? w_tgt : w_seq;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ptgt     <= 32'd0;
            r_pending  <= 1'b0;
            r_req      <= 1'b0;
            r_dpc4     <= 32'd0;
            r_inst     <= NOP_INST;
            r_dvalid   <= 1'b0;
            r_buf_inst <= NOP_INST;
            r_buf_pc4  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (w_xfer) begin
                        r_pc      <= w_next;
                        r_pending <= 1'b0;
                        if (wpcir) begin
                            r_inst   <= imem_rdata;
                            r_dpc4   <= w_pc4;
                            r_dvalid <= 1'b1;
                        end else begin
                            // Decode is stalled: park the word until it frees up.
                            r_buf_inst <= imem_rdata;
                            r_buf_pc4  <= w_pc4;
                            r_state    <= S_HOLD;
                            r_req      <= 1'b0;
                        end
                    end else begin
                        if (w_redir) begin
                            r_ptgt    <= w_tgt;
                            r_pending <= 1'b1;
                        end
                        if (wpcir) begin
                            r_inst   <= NOP_INST;
                            r_dvalid <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    // The buffered word is the delay slot, so pc can be retargeted directly.
                    if (w_redir) begin
                        r_pc <= w_tgt;
                    end
                    if (wpcir) begin
                        r_inst   <= r_buf_inst;
                        r_dpc4   <= r_buf_pc4;
                        r_dvalid <= 1'b1;
                        r_state  <= S_REQ;
                        r_req    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign dpc4      = r_dpc4;
    assign inst      = r_inst;
    assign dvalid    = r_dvalid;

endmodule
`default_nettype wire
